// File: rtl/alarm_match.sv
// alarm_match: settable BCD alarm time with synchronized keys and match/fire strobes.
module alarm_match #(
  parameter logic [5:0] RST_HH = 6'h07,
  parameter logic [6:0] RST_MM = 7'h00
) (
  input  logic       cclk,
  input  logic       rst_n,
  input  logic       set_btn,
  input  logic       inc_btn,
  input  logic       en_sw,
  input  logic [5:0] cur_hh,
  input  logic [6:0] cur_mm,
  output logic       cc1,
  output logic       cc2,
  output logic [5:0] alm_hh,
  output logic [6:0] alm_mm,
  output logic [1:0] mode
);
  typedef enum logic [1:0] {IDLE = 2'd0, SET_H = 2'd1, SET_M = 2'd2, BAD = 2'd3} mode_t;
  mode_t state, state_nx;
  logic [1:0] set_s, inc_s, en_s;
  logic set_h, inc_h, fire_r;
  logic set_ev, inc_ev, armed, hmatch, fmatch;
  logic [5:0] hh_nx;
  logic [6:0] mm_nx;
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      set_s <= '0;
      inc_s <= '0;
      en_s  <= '0;
      set_h <= 1'b0;
      inc_h <= 1'b0;
    end else begin
      set_s <= {set_s[0], set_btn};
      inc_s <= {inc_s[0], inc_btn};
      en_s  <= {en_s[0], en_sw};
      set_h <= set_s[1];
      inc_h <= inc_s[1];
    end
  // a set event on the same cycle swallows any inc event
  assign set_ev = set_s[1] & ~set_h;
  assign inc_ev = inc_s[1] & ~inc_h & ~set_ev;
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == BAD) state_nx = IDLE;
    else if (set_ev) state_nx = state == IDLE ? SET_H : state == SET_H ? SET_M : IDLE;
  end
  always_comb begin
    hh_nx = alm_hh == 6'h23 ? 6'h00 :
            alm_hh[3:0] == 4'd9 ? {alm_hh[5:4] + 2'd1, 4'd0} : {alm_hh[5:4], alm_hh[3:0] + 4'd1};
    mm_nx = alm_mm == 7'h59 ? 7'h00 :
            alm_mm[3:0] == 4'd9 ? {alm_mm[6:4] + 3'd1, 4'd0} : {alm_mm[6:4], alm_mm[3:0] + 4'd1};
  end
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      alm_hh <= RST_HH;
      alm_mm <= RST_MM;
    end else begin
      if (inc_ev && state == SET_H) alm_hh <= hh_nx;
      if (inc_ev && state == SET_M) alm_mm <= mm_nx;
    end
  assign armed  = en_s[1] & (state == IDLE);
  assign hmatch = cur_hh == alm_hh;
  assign fmatch = hmatch & (cur_mm == alm_mm);
  // cc2 fires on the rising edge of the armed full match, aligned with fire_r
  always_ff @(posedge cclk or negedge rst_n)
    if (!rst_n) begin
      cc1    <= 1'b0;
      cc2    <= 1'b0;
      fire_r <= 1'b0;
    end else begin
      cc1    <= hmatch & armed;
      fire_r <= fmatch & armed;
      cc2    <= fmatch & armed & ~fire_r;
    end
  assign mode = state;
endmodule

// File: tb/tb_alarm_match.sv
// tb_alarm_match: scoreboard bench with a decimal-time reference model of the alarm.
module tb_alarm_match;
  logic cclk = 0, rst_n = 0, set_btn = 0, inc_btn = 0, en_sw = 0;
  logic [5:0] cur_hh = 0, alm_hh;
  logic [6:0] cur_mm = 0, alm_mm;
  logic cc1, cc2;
  logic [1:0] mode;
  alarm_match dut (.cclk(cclk), .rst_n(rst_n), .set_btn(set_btn), .inc_btn(inc_btn),
    .en_sw(en_sw), .cur_hh(cur_hh), .cur_mm(cur_mm), .cc1(cc1), .cc2(cc2),
    .alm_hh(alm_hh), .alm_mm(alm_mm), .mode(mode));
  always #5 cclk = ~cclk;
  typedef struct {int md; int hh; int mm; int c1; int c2;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, pulses = 0;
  int m_mode = 0, m_h = 7, m_m = 0;
  bit fa_prev = 0;
  bit sh[$] = '{0, 0, 0, 0}, ih[$] = '{0, 0, 0, 0}, eh[$] = '{0, 0, 0, 0};
  function automatic logic [5:0] bcd_h(int v);
    return 6'((v / 10) * 16 + v % 10);
  endfunction
  function automatic logic [6:0] bcd_m(int v);
    return 7'((v / 10) * 16 + v % 10);
  endfunction
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: a key event is seen two edges after its level was first sampled high.
  always @(posedge cclk) begin
    bit set_ev, inc_ev, armed, c1, fa, c2;
    if (!rst_n) begin
      m_mode = 0; m_h = 7; m_m = 0; fa_prev = 0;
      sh = '{0, 0, 0, 0}; ih = '{0, 0, 0, 0}; eh = '{0, 0, 0, 0};
    end else begin
      sh.push_front(set_btn); void'(sh.pop_back());
      ih.push_front(inc_btn); void'(ih.pop_back());
      eh.push_front(en_sw); void'(eh.pop_back());
      set_ev = sh[2] && !sh[3];
      inc_ev = ih[2] && !ih[3] && !set_ev;
      armed = eh[2] && m_mode == 0;
      c1 = armed && cur_hh == bcd_h(m_h);
      fa = c1 && cur_mm == bcd_m(m_m);
      c2 = fa && !fa_prev;
      fa_prev = fa;
      if (inc_ev && m_mode == 1) m_h = (m_h + 1) % 24;
      if (inc_ev && m_mode == 2) m_m = (m_m + 1) % 60;
      if (set_ev) m_mode = (m_mode + 1) % 3;
      q.push_back('{m_mode, int'(bcd_h(m_h)), int'(bcd_m(m_m)), int'(c1), int'(c2)});
    end
  end
  always @(negedge cclk) begin
    exp_t e;
    if (cc2) pulses++;
    if (!rst_n) q.delete();
    else if (q.size() > 0) begin
      e = q.pop_front();
      chk("mode", int'(mode), e.md);
      chk("alm_hh", int'(alm_hh), e.hh);
      chk("alm_mm", int'(alm_mm), e.mm);
      chk("cc1", int'(cc1), e.c1);
      chk("cc2", int'(cc2), e.c2);
    end
  end
  task automatic tick(int n);
    repeat (n) begin @(posedge cclk); #1; end
  endtask
  task automatic press(bit s, bit i);
    set_btn = s; inc_btn = i; tick(3);
    set_btn = 0; inc_btn = 0; tick(3);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int p0;
    en_sw = 1; cur_hh = 6'h07; cur_mm = 7'h00;
    tick(3); rst_n = 1; tick(12);
    chk("fire_once_after_reset", pulses, 1);
    en_sw = 0;
    press(1, 0);
    repeat (17) press(0, 1);
    press(1, 0);
    repeat (5) press(0, 1);
    press(1, 0);
    chk("wrap_hh", int'(alm_hh), 'h00);
    chk("set_mm", int'(alm_mm), 'h05);
    press(1, 0); press(1, 0);
    repeat (54) press(0, 1);
    chk("mm_at_59", int'(alm_mm), 'h59);
    press(0, 1);
    chk("mm_wrap", int'(alm_mm), 'h00);
    chk("hh_kept", int'(alm_hh), 'h00);
    press(1, 0); press(1, 0);
    press(1, 1);
    chk("set_beats_inc_mode", int'(mode), 2);
    chk("set_beats_inc_hh", int'(alm_hh), 'h00);
    press(1, 0);
    cur_hh = 6'h00; cur_mm = 7'h00; tick(6);
    p0 = pulses;
    en_sw = 1; tick(6);
    cur_mm = 7'h01; tick(4);
    cur_hh = 6'h01; tick(4);
    chk("enable_fires_once", pulses - p0, 1);
    press(1, 0); press(1, 0);
    repeat (33) press(0, 1);
    chk("pre_reset_mm", int'(alm_mm), 'h33);
    rst_n = 0; #1;
    chk("async_mode", int'(mode), 0);
    chk("async_hh", int'(alm_hh), 'h07);
    chk("async_mm", int'(alm_mm), 'h00);
    chk("async_cc1", int'(cc1), 0);
    chk("async_cc2", int'(cc2), 0);
    tick(2);
    set_btn = 1; rst_n = 1; tick(10);
    chk("held_key_one_event", int'(mode), 1);
    set_btn = 0; tick(3);
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 24) == 0) set_btn = ~set_btn;
      if ($urandom_range(0, 3) == 0) inc_btn = ~inc_btn;
      if ($urandom_range(0, 40) == 0) en_sw = ~en_sw;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: begin cur_hh = bcd_h(m_h); cur_mm = bcd_m(m_m); end
          1: begin cur_hh = bcd_h(m_h); cur_mm = 7'($urandom); end
          default: begin cur_hh = 6'($urandom); cur_mm = 7'($urandom); end
        endcase
      end
      tick(1);
    end
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alarm_match.md
ALARM_MATCH -- requirements
Module: alarm_match

Interface
REQ-001 Parameter RST_HH, default 6'h07, reset value of alarm hour (BCD {tens[1:0],ones[3:0]}).
REQ-002 Parameter RST_MM, default 7'h00, reset value of alarm minute (BCD {tens[2:0],ones[3:0]}).
REQ-003 cclk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 set_btn  input  1  asynchronous level from the debounced "set" key; each rising edge advances the set mode.
REQ-006 inc_btn  input  1  asynchronous level from the debounced "increment" key; each rising edge increments the field being set.
REQ-007 en_sw  input  1  asynchronous alarm-enable switch level.
REQ-008 cur_hh  input  6  current hour, BCD, from the time counter, synchronous to cclk.
REQ-009 cur_mm  input  7  current minute, BCD, synchronous to cclk.
REQ-010 cc1  output  1  registered hour-match level, consumed by the ringer.
REQ-011 cc2  output  1  registered one-cycle alarm-fire strobe, consumed by the ringer.
REQ-012 alm_hh  output  6  stored alarm hour, BCD.
REQ-013 alm_mm  output  7  stored alarm minute, BCD.
REQ-014 mode  output  2  set-mode state: 0 IDLE, 1 SET_H, 2 SET_M.

Function
REQ-015 set_btn, inc_btn and en_sw SHALL each pass through a 2-flop synchronizer; a button event is a 0->1 transition on the synchronizer output, giving a one-cycle internal pulse 3 cycles after the input edge.
REQ-016 FSM SHALL move IDLE->SET_H->SET_M->IDLE on each set event; encoding 3 SHALL never be entered and, if present, SHALL go to IDLE next cycle.
REQ-017 In SET_H an inc event SHALL increment alm_hh in BCD: ones 9->0 with tens+1; 23->00 wrap.
REQ-018 In SET_M an inc event SHALL increment alm_mm in BCD: ones 9->0 with tens+1; 59->00 wrap.
REQ-019 In IDLE inc events SHALL be ignored.
REQ-020 If set and inc events occur on the same cycle, the set event SHALL take effect and the inc event SHALL be discarded.
REQ-021 armed = synchronized en_sw AND mode==IDLE.
REQ-022 hmatch = (cur_hh==alm_hh); fmatch = hmatch AND (cur_mm==alm_mm).
REQ-023 cc1 SHALL be registered hmatch AND armed (one cycle latency from inputs).
REQ-024 cc2 SHALL be high for exactly one cycle on the first cycle in which registered (fmatch AND armed) is 1 after being 0; it SHALL not re-fire while the match persists.
REQ-025 cc2 high SHALL imply cc1 high in the same cycle.
REQ-026 Re-entering IDLE or enabling en_sw while the time already equals the alarm SHALL fire cc2 once (rising edge of armed match).
REQ-027 Leaving IDLE or clearing en_sw SHALL drop cc1 and suppress cc2 on the next registered cycle.
REQ-028 Invalid BCD inputs on cur_hh/cur_mm SHALL be compared bitwise only; no correction.

Reset
REQ-029 rst_n low SHALL immediately force mode=0, alm_hh=RST_HH, alm_mm=RST_MM, cc1=0, cc2=0, synchronizers and edge-detect history to 0.
REQ-030 Reset asserted mid-setting SHALL discard the partial setting and restore parameter values.
REQ-031 After rst_n deasserts, a button held high SHALL produce one event (history reset to 0).

Verification
REQ-032 Reset, en_sw=1, cur=07:00 -> cc1=1 from cycle 4, cc2 single pulse same cycle, no further pulses while cur held 07:00.
REQ-033 set, 17 inc, set, 5 inc, set -> mode 1,2,0 in order; alm_hh=6'h00 (07+17 wraps 23->00), alm_mm=7'h05.
REQ-034 SET_M with alm_mm=7'h59, one inc -> alm_mm=7'h00, alm_hh unchanged.
REQ-035 set_btn and inc_btn rise same cycle in SET_H -> mode=2, alm_hh unchanged.
REQ-036 cur=07:00, en_sw=0 -> cc1=cc2=0; then en_sw=1 -> one cc2 pulse; cur->07:01 -> cc1=1, cc2=0; cur->08:00 -> cc1=0.
REQ-037 rst_n pulsed low while mode=2 with alm_mm=7'h33 -> outputs at reset values asynchronously, before next cclk edge.
